// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, LSB first, held data/valid with ack, frame and overrun flags.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse output.
//
// state     | meaning
// S_IDLE    | line idle, waiting for a falling edge on rxs
// S_START   | timing to mid start bit, rejects false starts
// S_DATA    | sampling 8 data bits at mid-bit, LSB first
// S_PARITY  | sampling the even-parity bit (parity build only)
// S_STOP    | sampling the stop bit, loads d or flags framing error
// S_WAIT_IDLE | line held low after a bad stop bit, waits for rxs=1
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       ack,
  output logic [7:0] d,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t          state, state_nxt;
  logic            rx_meta, rxs, rx_prev;
  logic [CW-1:0]   cnt;
  logic [2:0]      bitidx;
  logic [7:0]      shift;
  logic            fall, bit_tick, cnt_clr, byte_done, stop_bad;

  assign fall = rx_prev & ~rxs;

  // Two-flop synchronizer plus a third copy for start-edge detection; idle-high reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
      rx_prev <= rxs;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (fall) state_nxt = S_START;
      S_START:     if (bit_tick) state_nxt = rxs ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:      if (bit_tick && bitidx == 3'd7) state_nxt = S_PARITY;
      S_PARITY:    if (bit_tick) state_nxt = S_STOP;
`else
      S_DATA:      if (bit_tick && bitidx == 3'd7) state_nxt = S_STOP;
`endif
      S_STOP:      if (bit_tick) state_nxt = rxs ? S_IDLE : S_WAIT_IDLE;
      S_WAIT_IDLE: if (rxs) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    bit_tick = 1'b0;
    cnt_clr  = 1'b1;
    case (state)
      S_START: begin
        bit_tick = (cnt == CNT_HALF);
        cnt_clr  = bit_tick;
      end
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP: begin
        bit_tick = (cnt == CNT_FULL);
        cnt_clr  = bit_tick;
      end
      default: ;
    endcase
    byte_done = (state == S_STOP) && bit_tick && rxs;
    stop_bad  = (state == S_STOP) && bit_tick && !rxs;
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == S_PARITY && bit_tick) par_bit <= rxs;
      parity_err <= (state == S_STOP) && bit_tick && (par_bit != ^shift);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      bitidx    <= 3'd0;
      shift     <= 8'h00;
      d         <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CW'(1);
      if (state == S_START) begin
        bitidx <= 3'd0;
      end else if (state == S_DATA && bit_tick) begin
        shift[bitidx] <= rxs;
        bitidx        <= bitidx + 3'd1;
      end
      frame_err <= stop_bad;
      if (byte_done) d <= shift;
      // A completing byte wins over a same-cycle ack, so valid stays set.
      if (byte_done)  valid <= 1'b1;
      else if (ack)   valid <= 1'b0;
      if (ack)                     overrun <= 1'b0;
      else if (byte_done && valid) overrun <= 1'b1;
    end
  end

endmodule
